mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised iterative multiply/divide unit, successor to the pipeline's fixed-latency HI/LO block. It sits in the E stage alongside the ALU. Operations run one radix-2 step per cycle: shift-add for multiply, restoring division for divide. It adds multiply-accumulate modes, explicit divide-by-zero handling and a width parameter. HI/LO architectural registers live inside the block and are read combinationally.

## Interface
- WIDTH, 32, operand width and HI/LO width (≥4, even)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- Req  in  1  exception/interrupt request; while high, blocks acceptance of Start/HIWrite/LOWrite
- SrcA  in  WIDTH  operand A / HI-LO write data
- SrcB  in  WIDTH  operand B
- Start  in  1  launch operation MDUOp
- MDUOp  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU; others invalid
- HIWrite, LOWrite  in  1  write SrcA to HI / LO (mthi/mtlo)
- HIRead, LORead  in  1  select HI / LO onto Result
- Busy  out  1  stall request to hazard unit
- Result  out  WIDTH  HIRead ? HI : LORead ? LO : 0 (combinational)
- DivZero  out  1  one-cycle pulse: a divide by zero completed

## Operation
- States: IDLE, MUL, DIV, FIX. Iteration counter is $clog2(WIDTH) bits.
- Accept: in IDLE with Req low, priority is valid Start > HIWrite > LOWrite.
  - Start, HIWrite and LOWrite are ignored outside IDLE.
  - Invalid ops are ignored.
- Launch:
  - Latch |A|, |B| (signed ops) or A, B.
  - Latch result sign: A^B for products; quotient A^B, remainder sign of A.
  - Latch op; counter = WIDTH-1.
  - Go to MUL (ops 0,1,4–7) or DIV (ops 2,3).
- Divide by zero: go straight to FIX. FIX pulses DivZero and leaves HI/LO unchanged.
- MUL: one bit of SrcB per cycle into the 2·WIDTH product. After WIDTH steps, go to FIX.
- DIV: one restoring step per cycle, quotient bit from MSB. After WIDTH steps, go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Products: {HI,LO} ← P (MULT/U), {HI,LO}+P (MADD/U), {HI,LO}−P (MSUB/U), modulo 2^(2·WIDTH).
  - Divides: LO ← quotient (truncated toward zero), HI ← remainder.
  - Go to IDLE.
- Signed overflow: MIN/−1 gives LO=MIN, HI=0.
- Req does not abort an in-flight operation; the owning instruction has already committed.
- Busy = (Start & valid op & !Req & state==IDLE) | (state!=IDLE).
- Reset values:
  - HI, LO, counter and all operand regs = 0; state = IDLE.
  - Busy = 0 and DivZero = 0 (given Start=0); Result = 0.
  - Reset mid-operation discards the operation immediately.

## Timing
- Start sampled at the end of cycle c. Iterations run c+1..c+WIDTH; FIX runs in c+WIDTH+1.
- HI/LO update at the end of FIX. Busy is high in cycles c..c+WIDTH+1.
- Result shows the new value from c+WIDTH+2. For WIDTH=32, Busy lasts 34 cycles.
- Divide by zero: FIX in c+1. DivZero is high in c+1; Busy is high in c, c+1.
- HIWrite/LOWrite accepted in cycle c are visible on Result in c+1. Busy is not raised.
- A Start in the same cycle FIX completes is ignored (state≠IDLE). The hazard unit stalls on Busy.

## Configuration
- MDU_MADD_EN defined: ops 4–7 are valid, and FIX includes the accumulate adder.
- MDU_MADD_EN undefined:
  - Ops 4–7 are invalid: not accepted, Busy not raised, HI/LO untouched.
  - The accumulate path is removed.

## Structure
- mdu_pkg holds:
  - MDUOp encodings (MDU_MULT … MDU_MSUBU).
  - The state enum.
  - An is_signed/is_div/is_acc decode function.
- One sub-module, mdu_div_step: combinational single restoring-division step. Inputs are partial remainder, divisor and next dividend bit; outputs are the new remainder and quotient bit.

## Test plan
- MULT with A=0xFFFFFFFD, B=5 -> Busy for 34 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. Repeat with MULTU A=0xFFFFFFFF, B=2 -> HI=1, LO=0xFFFFFFFE.
- DIV with A=−7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV with A=0x80000000, B=−1 -> LO=0x80000000, HI=0.
- DIVU with A=7, B=0 (HI=LO=0x55) -> DivZero pulse in c+1, Busy 2 cycles, HI/LO stay 0x55.
- MTLO 0xFFFFFFFF, MTHI 0, then MADDU 1×1 -> HI=1, LO=0. Then MSUB 1×1 -> HI=0, LO=0xFFFFFFFF. Ops 4–7 are ignored without MDU_MADD_EN.
- Start with Req=1 -> no Busy, HI/LO unchanged. A MULT in flight with Req pulsed -> completes normally. A second Start mid-operation -> ignored.
- Assert reset at iteration 10 of a DIVU -> Busy=0 and HI=LO=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode encodings, FSM state type and opcode decode shared by the
// iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MADD  = 4'd4;
    localparam logic [3:0] MDU_MADDU = 4'd5;
    localparam logic [3:0] MDU_MSUB  = 4'd6;
    localparam logic [3:0] MDU_MSUBU = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } mdu_state_e;

    typedef struct packed {
        logic is_signed;
        logic is_div;
        logic is_acc;
    } mdu_dec_t;

    function automatic mdu_dec_t mdu_decode(input logic [3:0] op);
        mdu_dec_t d;
        d.is_signed = (op == MDU_MULT) || (op == MDU_DIV) ||
                      (op == MDU_MADD) || (op == MDU_MSUB);
        d.is_div    = (op == MDU_DIV) || (op == MDU_DIVU);
        d.is_acc    = (op >= MDU_MADD) && (op <= MDU_MSUBU);
        return d;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring-division step; shifts the next dividend bit into
// the partial remainder and subtracts the divisor when it fits.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // NOTE: every output is assigned on every path, so no latch is inferred.
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, divisor_i};
        // rem_i < divisor_i always holds, so a borrow out of bit WIDTH means "does not fit".
        q_o     = ~trial[WIDTH];
        rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Define MDU_MADD_EN to enable the multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU).
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Start,
    input  logic [3:0]       MDUOp,
    input  logic             HIWrite,
    input  logic             LOWrite,
    input  logic             HIRead,
    input  logic             LORead,
    output logic             Busy,
    output logic [WIDTH-1:0] Result,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state_q;
    logic [WIDTH-1:0]   hi_q, lo_q, a_q, b_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q, rneg_q, is_div_q, divzero_q;
`ifdef MDU_MADD_EN
    logic               acc_q, sub_q;
`endif

    mdu_dec_t           dec_in;
    logic               op_valid, accept, start_ok;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_mul_d, prod_div_d, prod_fix, hilo_d;
    logic [WIDTH-1:0]   div_rem, quo_fix, rem_fix;
    logic               div_qbit;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (prod_q[2*WIDTH-1:WIDTH]),
        .divisor_i (b_q),
        .bit_i     (prod_q[WIDTH-1]),
        .rem_o     (div_rem),
        .q_o       (div_qbit)
    );

    always_comb begin
        dec_in   = mdu_decode(MDUOp);
`ifdef MDU_MADD_EN
        op_valid = !MDUOp[3];
`else
        op_valid = !MDUOp[3] && !dec_in.is_acc;
`endif
        accept   = (state_q == IDLE) && !Req;
        start_ok = accept && Start && op_valid;
        a_abs    = (dec_in.is_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
        b_abs    = (dec_in.is_signed && SrcB[WIDTH-1]) ? -SrcB : SrcB;

        // Multiplier sits in the low half and shifts out LSB-first as the product grows.
        mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{prod_q[0]}}};
        prod_mul_d = {mul_sum, prod_q[WIDTH-1:1]};
        // Dividend shifts out of the low half MSB-first while quotient bits shift in.
        prod_div_d = {div_rem, prod_q[WIDTH-2:0], div_qbit};

        prod_fix = neg_q  ? -prod_q : prod_q;
        quo_fix  = neg_q  ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            hilo_d = {rem_fix, quo_fix};
        end
`ifdef MDU_MADD_EN
        else if (acc_q) begin
            hilo_d = sub_q ? {hi_q, lo_q} - prod_fix : {hi_q, lo_q} + prod_fix;
        end
`endif
        else begin
            hilo_d = prod_fix;
        end
    end

    assign Busy    = (state_q != IDLE) || start_ok;
    assign DivZero = divzero_q;
    assign Result  = HIRead ? hi_q : (LORead ? lo_q : '0);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            is_div_q  <= 1'b0;
            divzero_q <= 1'b0;
`ifdef MDU_MADD_EN
            acc_q     <= 1'b0;
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        a_q      <= a_abs;
                        b_q      <= b_abs;
                        prod_q   <= {{WIDTH{1'b0}}, dec_in.is_div ? a_abs : b_abs};
                        neg_q    <= dec_in.is_signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        rneg_q   <= dec_in.is_signed & SrcA[WIDTH-1];
                        is_div_q <= dec_in.is_div;
                        cnt_q    <= CW'(WIDTH - 1);
`ifdef MDU_MADD_EN
                        acc_q    <= dec_in.is_acc;
                        sub_q    <= (MDUOp == MDU_MSUB) || (MDUOp == MDU_MSUBU);
`endif
                        if (dec_in.is_div && (SrcB == '0)) begin
                            divzero_q <= 1'b1;
                            state_q   <= FIX;
                        end else begin
                            state_q <= dec_in.is_div ? DIV : MUL;
                        end
                    end else if (accept && HIWrite) begin
                        hi_q <= SrcA;
                    end else if (accept && LOWrite) begin
                        lo_q <= SrcA;
                    end
                end
                MUL: begin
                    prod_q <= prod_mul_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= FIX;
                end
                DIV: begin
                    prod_q <= prod_div_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= FIX;
                end
                FIX: begin
                    if (!divzero_q) {hi_q, lo_q} <= hilo_d;
                    divzero_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and random checks of mdu_iter against an arithmetic HI/LO model.
// Honours MDU_MADD_EN the same way as the design.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W = 32;
`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, Req, Start, HIWrite, LOWrite, HIRead, LORead;
    logic [W-1:0] SrcA, SrcB;
    logic [3:0]   MDUOp;
    logic         Busy, DivZero;
    logic [W-1:0] Result;

    int           n_pass  = 0;
    int           n_total = 0;
    logic [W-1:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .Req     (Req),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .Start   (Start),
        .MDUOp   (MDUOp),
        .HIWrite (HIWrite),
        .LOWrite (LOWrite),
        .HIRead  (HIRead),
        .LORead  (LORead),
        .Busy    (Busy),
        .Result  (Result),
        .DivZero (DivZero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: new HI/LO from plain integer arithmetic on the architectural values.
    task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output bit dz);
        longint         sa, sb;
        logic [2*W-1:0] hl, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hl = {m_hi, m_lo};
        dz = 1'b0;
        if (op == MDU_DIV || op == MDU_DIVU) begin
            if (b == '0) begin
                dz = 1'b1;
                return;
            end
            if (op == MDU_DIV) begin
                m_lo = W'(sa / sb);
                m_hi = W'(sa % sb);
            end else begin
                m_lo = a / b;
                m_hi = a % b;
            end
        end else begin
            p = op[0] ? 64'(a) * 64'(b) : 64'(sa * sb);
            case (op)
                MDU_MULT, MDU_MULTU: hl = p;
                MDU_MADD, MDU_MADDU: hl = hl + p;
                default:             hl = hl - p;
            endcase
            {m_hi, m_lo} = hl;
        end
    endtask

    task automatic compare_hilo(input string tag);
        logic [W-1:0] h, l;
        HIRead = 1'b1; #1; h = Result; HIRead = 1'b0;
        LORead = 1'b1; #1; l = Result; LORead = 1'b0;
        check({tag, "_hi"}, h, m_hi);
        check({tag, "_lo"}, l, m_lo);
    endtask

    task automatic write_hilo(input string tag, input bit to_hi, input logic [W-1:0] v, input bit req);
        SrcA = v; HIWrite = to_hi; LOWrite = !to_hi; Req = req; #1;
        check({tag, "_busy"}, Busy, 1'b0);
        @(posedge clk); #1;
        HIWrite = 1'b0; LOWrite = 1'b0; Req = 1'b0;
        if (!req) begin
            if (to_hi) m_hi = v;
            else       m_lo = v;
        end
        compare_hilo(tag);
    endtask

    // Launch one op, optionally with Req at launch, a Req pulse or a second Start in flight,
    // or HIWrite raised alongside Start; then check Busy length, DivZero timing and HI/LO.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit launch_req, input int req_cyc,
                          input int restart_cyc, input bit hiw);
        bit valid, dz, eff;
        int busy_cnt, dz_at, cyc, exp_busy, exp_dz;
        valid = (op < 4'd4) || (MADD_EN && op < 4'd8);
        eff   = valid && !launch_req;
        dz    = 1'b0;
        if (eff) model_op(op, a, b, dz);
        if (hiw && !valid && !launch_req) m_hi = a;
        exp_busy = !eff ? 0 : (dz ? 2 : W + 2);
        exp_dz   = (eff && dz) ? 1 : -1;

        SrcA = a; SrcB = b; MDUOp = op; Req = launch_req; HIWrite = hiw; Start = 1'b1; #1;
        busy_cnt = 0; dz_at = -1; cyc = 0;
        while (Busy === 1'b1 && cyc < 100) begin
            if (DivZero === 1'b1) dz_at = cyc;
            busy_cnt++;
            @(posedge clk); #1;
            cyc++;
            HIWrite = 1'b0;
            Start   = (cyc == restart_cyc);
            Req     = (cyc == req_cyc);
            if (Start) begin
                SrcA = ~a; SrcB = 32'd7; MDUOp = MDU_MULTU;
            end
            #1;
        end
        if (busy_cnt == 0) begin
            @(posedge clk); #1;
        end
        Start = 1'b0; Req = 1'b0; HIWrite = 1'b0; #1;
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({tag, "_busy_after"}, Busy, 1'b0);
        check({tag, "_divzero_at"}, 64'(dz_at), 64'(exp_dz));
        compare_hilo(tag);
    endtask

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] ra, rb;

        reset = 1'b1; Req = 1'b0; Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
        HIRead = 1'b0; LORead = 1'b0; SrcA = '0; SrcB = '0; MDUOp = '0;
        m_hi = '0; m_lo = '0;
        #2;
        check("rst_busy", Busy, 1'b0);
        check("rst_divzero", DivZero, 1'b0);
        check("rst_result", Result, '0);
        compare_hilo("rst");
        #6 reset = 1'b0;
        @(posedge clk); #1;

        run_op("mult",  MDU_MULT,  32'hFFFF_FFFD, 32'd5,        1'b0, -1, -1, 1'b0);
        run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2,        1'b0, -1, -1, 1'b0);
        run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2,        1'b0, -1, -1, 1'b0);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, -1, 1'b0);

        write_hilo("mthi55", 1'b1, 32'h55, 1'b0);
        write_hilo("mtlo55", 1'b0, 32'h55, 1'b0);
        run_op("divu_zero", MDU_DIVU, 32'd7, 32'd0,             1'b0, -1, -1, 1'b0);
        run_op("div_zero",  MDU_DIV,  32'hFFFF_FFF0, 32'd0,     1'b0, -1, -1, 1'b0);

        write_hilo("mtlo_ones", 1'b0, 32'hFFFF_FFFF, 1'b0);
        write_hilo("mthi_zero", 1'b1, 32'h0, 1'b0);
        run_op("maddu", MDU_MADDU, 32'd1, 32'd1,                1'b0, -1, -1, 1'b0);
        run_op("msub",  MDU_MSUB,  32'd1, 32'd1,                1'b0, -1, -1, 1'b0);
        run_op("madd",  MDU_MADD,  32'hFFFF_FFFE, 32'd3,        1'b0, -1, -1, 1'b0);
        run_op("msubu", MDU_MSUBU, 32'h1234_5678, 32'h9ABC,     1'b0, -1, -1, 1'b0);

        run_op("start_req", MDU_MULT, 32'd9, 32'd9,             1'b1, -1, -1, 1'b0);
        write_hilo("mthi_req", 1'b1, 32'hDEAD_BEEF, 1'b1);
        run_op("mult_reqpulse", MDU_MULT, 32'h0001_2345, 32'hFFFF_F000, 1'b0, 3, -1, 1'b0);
        run_op("mult_restart",  MDU_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, -1, 5, 1'b0);
        run_op("divu_restart",  MDU_DIVU, 32'hFFFF_FFFF, 32'd10,        1'b0, -1, 33, 1'b0);
        run_op("start_and_mthi", MDU_MULTU, 32'd3, 32'd4,       1'b0, -1, -1, 1'b1);
        run_op("invalid_mthi", 4'd12, 32'hCAFE_0001, 32'd4,     1'b0, -1, -1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            rop = 4'($urandom_range(0, 9));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = '1; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), rop, ra, rb, 1'b0, -1, -1, 1'b0);
        end

        // Reset asserted between clock edges during iteration 10 of a DIVU.
        write_hilo("pre_rst_hi", 1'b1, 32'h1111_2222, 1'b0);
        SrcA = 32'd1000; SrcB = 32'd3; MDUOp = MDU_DIVU; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("rst_mid_busy_before", Busy, 1'b1);
        reset = 1'b1; #1;
        m_hi = '0; m_lo = '0;
        check("rst_mid_busy", Busy, 1'b0);
        check("rst_mid_divzero", DivZero, 1'b0);
        compare_hilo("rst_mid");
        #1 reset = 1'b0;
        @(posedge clk); #1;
        run_op("after_rst", MDU_DIVU, 32'd100, 32'd7,           1'b0, -1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
